decoder_2to4_reg: RTL and testbench

- Registered 2-to-4 line decoder. The 2-bit select {a,b} drives exactly one of four one-hot outputs l, m, n, o.
- Outputs are registered one cycle after the select; an enable gates decoding.
- Sits between control/address logic and downstream per-line selects (chip selects, mux selects).
- Optional per-line saturating hit counters support coverage and debug.

---
 rtl/decoder_2to4_reg_pkg.sv | 12 +
 rtl/decoder_2to4_reg_if.sv | 31 +++
 rtl/decoder_2to4_reg_hit_counter.sv | 19 +
 rtl/decoder_2to4_reg.sv | 78 +++++++
 tb/tb_decoder_2to4_reg.sv | 131 +++++++++++++
 5 files changed

// File: rtl/decoder_2to4_reg_pkg.sv
// Shared select codes, line count and counter defaults for the registered 2-to-4 decoder.
package decoder_pkg;
  typedef logic [1:0] sel_t;

  localparam sel_t SEL_L = 2'b00;
  localparam sel_t SEL_M = 2'b01;
  localparam sel_t SEL_N = 2'b10;
  localparam sel_t SEL_O = 2'b11;

  localparam int NUM_LINES = 4;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/decoder_2to4_reg_if.sv
// Select/enable in, one-hot lines plus valid/chg out; hit_cnt/cnt_clr exist only with DECODER_HIT_CNT_EN.
interface decoder_2to4_reg_if #(
  parameter int CNT_W = decoder_pkg::CNT_W_DEF
);
  import decoder_pkg::*;

  if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
    $error("decoder_2to4_reg_if: CNT_W must be in 2..16");
  end

  logic en;
  logic a;
  logic b;
  logic l;
  logic m;
  logic n;
  logic o;
  logic valid;
  logic chg;

`ifdef DECODER_HIT_CNT_EN
  logic                       cnt_clr;
  logic [NUM_LINES*CNT_W-1:0] hit_cnt;

  modport master (output en, a, b, cnt_clr, input l, m, n, o, valid, chg, hit_cnt);
  modport slave  (input en, a, b, cnt_clr, output l, m, n, o, valid, chg, hit_cnt);
`else
  modport master (output en, a, b, input l, m, n, o, valid, chg);
  modport slave  (input en, a, b, output l, m, n, o, valid, chg);
`endif
endinterface

// File: rtl/decoder_2to4_reg_hit_counter.sv
// Saturating per-line hit counter; result visible the cycle after the edge.
// No backpressure: clr wins over inc, and inc at all-ones holds the value.
module decoder_hit_counter #(
  parameter int CNT_W = decoder_pkg::CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/decoder_2to4_reg.sv
// Registered 2-to-4 decoder with change pulse; 1-cycle latency, accepts a select every cycle (no backpressure).
// Optional per-line saturating hit counters are built when DECODER_HIT_CNT_EN is defined.
module decoder_2to4_reg
  import decoder_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter int CNT_W      = CNT_W_DEF
) (
  input logic               clk,
  input logic               rst,
  decoder_2to4_reg_if.slave bus
);
  if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
    $error("decoder_2to4_reg: CNT_W must be in 2..16");
  end

  sel_t                 code;
  logic [NUM_LINES-1:0] hot_d;
  logic [NUM_LINES-1:0] hot_q;
  logic                 valid_q;
  logic                 chg_q;
  sel_t                 prev_code;
  logic                 prev_vld;

  assign code = {bus.a, bus.b};

  // hot_d is indexed by select code, so bit 0 is line l.
  always_comb begin
    hot_d = '0;
    if (bus.en) begin
      hot_d[code] = 1'b1;
    end
  end

  // History survives disabled cycles so chg compares against the last enabled code.
  always_ff @(posedge clk) begin
    if (rst) begin
      hot_q     <= '0;
      valid_q   <= 1'b0;
      chg_q     <= 1'b0;
      prev_code <= SEL_L;
      prev_vld  <= 1'b0;
    end else begin
      hot_q   <= hot_d;
      valid_q <= bus.en;
      chg_q   <= bus.en && prev_vld && (code != prev_code);
      if (bus.en) begin
        prev_code <= code;
        prev_vld  <= 1'b1;
      end
    end
  end

  assign bus.l     = hot_q[SEL_L] ^ ACTIVE_LOW;
  assign bus.m     = hot_q[SEL_M] ^ ACTIVE_LOW;
  assign bus.n     = hot_q[SEL_N] ^ ACTIVE_LOW;
  assign bus.o     = hot_q[SEL_O] ^ ACTIVE_LOW;
  assign bus.valid = valid_q;
  assign bus.chg   = chg_q;

`ifdef DECODER_HIT_CNT_EN
  logic [CNT_W-1:0] cnt [NUM_LINES];

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_cnt
    decoder_hit_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (bus.cnt_clr),
      .inc (hot_d[i]),
      .cnt (cnt[i])
    );
  end

  assign bus.hit_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};
`endif
endmodule

// File: tb/tb_decoder_2to4_reg.sv
// Directed plus random stimulus with a scoreboard queue, checking active-high and active-low instances.
module tb_decoder_2to4_reg;
  logic clk;
  logic rst;

  decoder_2to4_reg_if #(.CNT_W(2)) bus_hi ();
  decoder_2to4_reg_if #(.CNT_W(2)) bus_lo ();

  decoder_2to4_reg #(.ACTIVE_LOW(1'b0), .CNT_W(2)) dut_hi (
    .clk (clk),
    .rst (rst),
    .bus (bus_hi)
  );

  decoder_2to4_reg #(.ACTIVE_LOW(1'b1), .CNT_W(2)) dut_lo (
    .clk (clk),
    .rst (rst),
    .bus (bus_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] lines;
    logic       valid;
    logic       chg;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb [$];
  int         passed = 0;
  int         total  = 0;
  logic       m_prev_v;
  logic [1:0] m_prev;
  logic [1:0] m_cnt [4];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input logic r, input logic e, input logic aa, input logic bb, input logic clr);
    exp_t       x;
    logic [1:0] code;
    rst       = r;
    bus_hi.en = e;
    bus_hi.a  = aa;
    bus_hi.b  = bb;
    bus_lo.en = e;
    bus_lo.a  = aa;
    bus_lo.b  = bb;
`ifdef DECODER_HIT_CNT_EN
    bus_hi.cnt_clr = clr;
    bus_lo.cnt_clr = clr;
`endif
    code = {aa, bb};
    x    = '0;
    if (r) begin
      m_prev_v = 1'b0;
      m_prev   = 2'b00;
      for (int i = 0; i < 4; i++) m_cnt[i] = 2'd0;
    end else begin
      if (e) begin
        x.lines  = 4'b1000 >> code;
        x.valid  = 1'b1;
        x.chg    = m_prev_v && (code != m_prev);
        m_prev   = code;
        m_prev_v = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
        if (clr) m_cnt[i] = 2'd0;
        else if (e && (code == i) && (m_cnt[i] != 2'd3)) m_cnt[i] = m_cnt[i] + 2'd1;
      end
    end
    x.cnt = {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]};
    sb.push_back(x);

    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("hi_lines", {4'b0, bus_hi.l, bus_hi.m, bus_hi.n, bus_hi.o}, {4'b0, x.lines});
    chk("hi_valid", {7'b0, bus_hi.valid}, {7'b0, x.valid});
    chk("hi_chg",   {7'b0, bus_hi.chg},   {7'b0, x.chg});
    chk("lo_lines", {4'b0, bus_lo.l, bus_lo.m, bus_lo.n, bus_lo.o}, {4'b0, ~x.lines});
    chk("lo_valid", {7'b0, bus_lo.valid}, {7'b0, x.valid});
    chk("lo_chg",   {7'b0, bus_lo.chg},   {7'b0, x.chg});
`ifdef DECODER_HIT_CNT_EN
    chk("hi_cnt", bus_hi.hit_cnt, x.cnt);
    chk("lo_cnt", bus_lo.hit_cnt, x.cnt);
`endif
  endtask

  initial begin
    // reset held two cycles with a live select
    step(1, 1, 1, 1, 0);
    step(1, 1, 1, 1, 0);
    // sweep all codes
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0);
    // repeat, gap, resume with same code
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    // gap then a different code must still flag a change
    step(0, 0, 1, 1, 0);
    step(0, 1, 1, 0, 0);
    // saturate line o, then clear with a coincident enable
    for (int i = 0; i < 5; i++) step(0, 1, 1, 1, 0);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 1);
    // reset while o is active, first decode after release
    step(0, 1, 1, 1, 0);
    step(1, 1, 1, 1, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
